queue_gate_control: RTL and testbench

Time-aware gate generator for one egress port. It walks a per-port gate control list (GCL) held in an external single-port RAM, one entry per time slot, and drives the 8-bit gate control vector to output_schedule_control. The GCL cycle is aligned to the global time-sync cycle-start pulse. When the block is disabled, all gates are held open.

---
 rtl/queue_gate_control_pkg.sv | 11 +
 rtl/gcl_slot_timer.sv | 60 ++++++
 rtl/queue_gate_control.sv | 114 +++++++++++
 tb/tb_queue_gate_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_gate_control_pkg.sv
// Shared types and constants for the per-port time-aware gate generator.
package queue_gate_control_pkg;
    typedef enum logic [1:0] {
        INIT_S = 2'd0,
        LOAD_S = 2'd1,
        RUN_S  = 2'd2
    } qgc_state_t;

    localparam logic [7:0] GATE_ALL_OPEN = 8'hFF;
    localparam int         GCL_RD_LAT    = 1;
endpackage

// File: rtl/gcl_slot_timer.sv
// Slot cycle counter and slot-index sequencer; slot length and count are
// clamped to 2 and 1 and picked up at each slot start.
module gcl_slot_timer #(
    parameter int GCL_ADDR_W = 10,
    parameter int SLOT_LEN_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_start,
    input  logic                  i_run,
    input  logic [SLOT_LEN_W-1:0] iv_time_slot_length,
    input  logic [GCL_ADDR_W:0]   iv_cycle_slot_num,
    output logic                  o_prefetch,
    output logic                  o_boundary,
    output logic [GCL_ADDR_W-1:0] ov_slot,
    output logic [GCL_ADDR_W-1:0] ov_after_next_slot,
    output logic [GCL_ADDR_W-1:0] ov_first_next_slot
);
    logic [SLOT_LEN_W-1:0] cnt, leff, leff_live;
    logic [GCL_ADDR_W:0]   neff_m1;
    logic [GCL_ADDR_W-1:0] next_slot;

    function automatic logic [GCL_ADDR_W-1:0] wrap_next(input logic [GCL_ADDR_W-1:0] s,
                                                        input logic [GCL_ADDR_W:0]   lim);
        if ({1'b0, s} >= lim) return '0;
        return s + 1'b1;
    endfunction

    assign leff_live = (iv_time_slot_length < SLOT_LEN_W'(2)) ? SLOT_LEN_W'(2) : iv_time_slot_length;
    assign neff_m1   = (iv_cycle_slot_num == '0) ? '0 : iv_cycle_slot_num - 1'b1;

    assign next_slot          = wrap_next(ov_slot, neff_m1);
    assign ov_after_next_slot = wrap_next(next_slot, neff_m1);
    assign ov_first_next_slot = wrap_next('0, neff_m1);

    // rdata for the prefetch is valid in the cnt = 1 cycle
    assign o_prefetch = i_run && (cnt == SLOT_LEN_W'(1));
    assign o_boundary = i_run && (cnt == leff - 1'b1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            leff    <= SLOT_LEN_W'(2);
            ov_slot <= '0;
        end else if (i_clr || i_start) begin
            cnt     <= '0;
            leff    <= leff_live;
            ov_slot <= '0;
        end else if (i_run) begin
            if (o_boundary) begin
                cnt     <= '0;
                leff    <= leff_live;
                ov_slot <= next_slot;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/queue_gate_control.sv
// Walks the gate control list in an external RAM, aligned to the time-sync
// cycle-start pulse, and drives the 8-bit gate vector for one egress port.
module queue_gate_control
    import queue_gate_control_pkg::*;
#(
    parameter int GCL_ADDR_W = 10,
    parameter int SLOT_LEN_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_qgc_enable,
    input  logic                  i_timer_rst,
    input  logic [SLOT_LEN_W-1:0] iv_time_slot_length,
    input  logic [GCL_ADDR_W:0]   iv_cycle_slot_num,
    output logic                  o_gcl_rd,
    output logic [GCL_ADDR_W-1:0] ov_gcl_raddr,
    input  logic [7:0]            iv_gcl_rdata,
    output logic [7:0]            ov_gate_ctrl_vector,
    output logic [GCL_ADDR_W-1:0] ov_current_slot,
    output logic [1:0]            ov_qgc_state
);
    qgc_state_t            state, state_nxt;
    logic                  rd_nxt;
    logic [GCL_ADDR_W-1:0] raddr_nxt;
    logic [7:0]            vec_nxt, nvec, nvec_nxt;
    logic [GCL_RD_LAT-1:0] rd_pipe;
    logic                  rd_vld;
    logic                  tmr_clr, tmr_start, tmr_run;
    logic                  prefetch, boundary;
    logic [GCL_ADDR_W-1:0] after_next_slot, first_next_slot;

    gcl_slot_timer #(.GCL_ADDR_W(GCL_ADDR_W), .SLOT_LEN_W(SLOT_LEN_W)) u_timer (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_clr               (tmr_clr),
        .i_start             (tmr_start),
        .i_run               (tmr_run),
        .iv_time_slot_length (iv_time_slot_length),
        .iv_cycle_slot_num   (iv_cycle_slot_num),
        .o_prefetch          (prefetch),
        .o_boundary          (boundary),
        .ov_slot             (ov_current_slot),
        .ov_after_next_slot  (after_next_slot),
        .ov_first_next_slot  (first_next_slot)
    );

    assign rd_vld       = rd_pipe[GCL_RD_LAT-1];
    assign ov_qgc_state = state;

    always_comb begin
        state_nxt = state;
        rd_nxt    = 1'b0;
        raddr_nxt = ov_gcl_raddr;
        vec_nxt   = ov_gate_ctrl_vector;
        nvec_nxt  = nvec;
        tmr_clr   = 1'b0;
        tmr_start = 1'b0;
        tmr_run   = 1'b0;
        if (!i_qgc_enable) begin
            state_nxt = INIT_S;
            vec_nxt   = GATE_ALL_OPEN;
            raddr_nxt = '0;
            tmr_clr   = 1'b1;
        end else if (i_timer_rst) begin
            // current vector is held until entry 0 arrives
            state_nxt = LOAD_S;
            rd_nxt    = 1'b1;
            raddr_nxt = '0;
        end else begin
            case (state)
                INIT_S: vec_nxt = GATE_ALL_OPEN;
                LOAD_S: begin
                    if (rd_vld) begin
                        vec_nxt   = iv_gcl_rdata;
                        tmr_start = 1'b1;
                        rd_nxt    = 1'b1;
                        raddr_nxt = first_next_slot;
                        state_nxt = RUN_S;
                    end
                end
                RUN_S: begin
                    tmr_run = 1'b1;
                    if (prefetch) nvec_nxt = iv_gcl_rdata;
                    if (boundary) begin
                        // with a 2-cycle slot the prefetch and boundary coincide
                        vec_nxt   = prefetch ? iv_gcl_rdata : nvec;
                        rd_nxt    = 1'b1;
                        raddr_nxt = after_next_slot;
                    end
                end
                default: state_nxt = INIT_S;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= INIT_S;
            o_gcl_rd            <= 1'b0;
            ov_gcl_raddr        <= '0;
            ov_gate_ctrl_vector <= GATE_ALL_OPEN;
            nvec                <= GATE_ALL_OPEN;
            rd_pipe             <= '0;
        end else begin
            state               <= state_nxt;
            o_gcl_rd            <= rd_nxt;
            ov_gcl_raddr        <= raddr_nxt;
            ov_gate_ctrl_vector <= vec_nxt;
            nvec                <= nvec_nxt;
            rd_pipe[0]          <= o_gcl_rd;
            for (int i = 1; i < GCL_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
endmodule

// File: tb/tb_queue_gate_control.sv
// Directed bench for queue_gate_control with a RAM model and a cycle-indexed
// scoreboard of expected outputs.
module tb_queue_gate_control;
    localparam int A  = 10;
    localparam int SW = 16;
    localparam int K_VEC = 0, K_SLOT = 1, K_RD = 2, K_ADDR = 3, K_STATE = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_qgc_enable;
    logic          i_timer_rst;
    logic [SW-1:0] iv_time_slot_length;
    logic [A:0]    iv_cycle_slot_num;
    logic          o_gcl_rd;
    logic [A-1:0]  ov_gcl_raddr;
    logic [7:0]    iv_gcl_rdata = 8'h00;
    logic [7:0]    ov_gate_ctrl_vector;
    logic [A-1:0]  ov_current_slot;
    logic [1:0]    ov_qgc_state;

    logic [7:0] gcl_mem [0:(1<<A)-1];

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0, r0;

    queue_gate_control #(.GCL_ADDR_W(A), .SLOT_LEN_W(SW)) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_qgc_enable        (i_qgc_enable),
        .i_timer_rst         (i_timer_rst),
        .iv_time_slot_length (iv_time_slot_length),
        .iv_cycle_slot_num   (iv_cycle_slot_num),
        .o_gcl_rd            (o_gcl_rd),
        .ov_gcl_raddr        (ov_gcl_raddr),
        .iv_gcl_rdata        (iv_gcl_rdata),
        .ov_gate_ctrl_vector (ov_gate_ctrl_vector),
        .ov_current_slot     (ov_current_slot),
        .ov_qgc_state        (ov_qgc_state)
    );

    always #4 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_gcl_rd) iv_gcl_rdata <= gcl_mem[ov_gcl_raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_VEC:   return 32'(ov_gate_ctrl_vector);
            K_SLOT:  return 32'(ov_current_slot);
            K_RD:    return 32'(o_gcl_rd);
            K_ADDR:  return 32'(ov_gcl_raddr);
            default: return 32'(ov_qgc_state);
        endcase
    endfunction

    function automatic void push(input int c, input int kind, input int v, input string tag);
        sb.push_back('{c, kind, 32'(v), tag});
    endfunction

    task automatic tick();
        int i;
        @(posedge i_clk);
        cyc++;
        #1;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                if (sb[i].cyc == cyc) chk(sb[i].tag, observe(sb[i].kind), sb[i].val);
                else chk({sb[i].tag, "_missed"}, 32'(sb[i].cyc), 32'(cyc));
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Expected schedule after a cycle-start pulse sampled in cycle t
    task automatic expect_run(input int t, input int l, input int n, input int nslots, input int upto);
        int leff, neff, s;
        leff = (l < 2) ? 2 : l;
        neff = (n < 1) ? 1 : n;
        push(t + 1, K_RD, 1, "rd_load");
        push(t + 1, K_ADDR, 0, "addr_load");
        push(t + 1, K_STATE, 1, "state_load");
        push(t + 2, K_RD, 0, "rd_pulse_end");
        for (int k = 0; k < nslots; k++) begin
            s = t + 3 + k * leff;
            if (s > upto) break;
            push(s, K_VEC, int'(gcl_mem[k % neff]), "vec_slot_start");
            push(s, K_SLOT, k % neff, "cur_slot");
            push(s, K_RD, 1, "rd_prefetch");
            push(s, K_ADDR, (k + 1) % neff, "addr_prefetch");
            push(s, K_STATE, 2, "state_run");
            if (s + 1 <= upto) push(s + 1, K_RD, 0, "rd_one_cycle");
            if (s + leff - 1 <= upto) push(s + leff - 1, K_VEC, int'(gcl_mem[k % neff]), "vec_slot_end");
        end
    endtask

    task automatic pulse_start(output int t);
        i_timer_rst = 1'b1;
        t = cyc;
    endtask

    initial begin
        for (int i = 0; i < (1 << A); i++) gcl_mem[i] = 8'(i * 7 + 3);
        i_rst_n = 1'b0;
        i_qgc_enable = 1'b0;
        i_timer_rst = 1'b0;
        iv_time_slot_length = 16'd10;
        iv_cycle_slot_num = 11'd3;
        tick();
        tick();
        chk("rst_vec", 32'(ov_gate_ctrl_vector), 32'hFF);
        chk("rst_rd", 32'(o_gcl_rd), 32'h0);
        chk("rst_addr", 32'(ov_gcl_raddr), 32'h0);
        chk("rst_slot", 32'(ov_current_slot), 32'h0);
        chk("rst_state", 32'(ov_qgc_state), 32'h0);
        i_rst_n = 1'b1;
        tick();

        // enabled but never started: stays all-open in INIT_S
        i_qgc_enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            push(cyc + i, K_VEC, 8'hFF, "idle_vec");
            push(cyc + i, K_RD, 0, "idle_rd");
            push(cyc + i, K_STATE, 0, "idle_state");
        end
        run_to(cyc + 12);

        // basic 3-slot list, L = 10
        gcl_mem[0] = 8'h01; gcl_mem[1] = 8'h82; gcl_mem[2] = 8'hF0;
        pulse_start(t0);
        push(t0 + 1, K_VEC, 8'hFF, "vec_before_load");
        push(t0 + 2, K_VEC, 8'hFF, "vec_before_load");
        push(t0 + 12, K_RD, 0, "rd_quiet");
        expect_run(t0, 10, 3, 4, t0 + 100);
        tick();
        i_timer_rst = 1'b0;
        run_to(t0 + 2 + 4 * 10);

        // resync in the middle of slot 1
        pulse_start(t0);
        expect_run(t0, 10, 3, 2, t0 + 17);
        tick();
        i_timer_rst = 1'b0;
        run_to(t0 + 17);
        pulse_start(r0);
        push(r0 + 1, K_VEC, 8'h82, "resync_hold");
        push(r0 + 2, K_VEC, 8'h82, "resync_hold");
        push(r0 + 2, K_SLOT, 1, "resync_slot_hold");
        expect_run(r0, 10, 3, 3, r0 + 100);
        tick();
        i_timer_rst = 1'b0;
        run_to(r0 + 2 + 3 * 10);

        // minimum slot length: L = 0 and L = 1 both give 2-cycle slots
        for (int l = 0; l < 2; l++) begin
            iv_time_slot_length = 16'(l);
            pulse_start(t0);
            expect_run(t0, l, 3, 7, t0 + 100);
            tick();
            i_timer_rst = 1'b0;
            run_to(t0 + 2 + 7 * 2);
        end

        // disable mid-run, then restart
        iv_time_slot_length = 16'd10;
        pulse_start(t0);
        expect_run(t0, 10, 3, 2, t0 + 16);
        tick();
        i_timer_rst = 1'b0;
        run_to(t0 + 16);
        i_qgc_enable = 1'b0;
        push(cyc + 1, K_VEC, 8'hFF, "dis_vec");
        push(cyc + 1, K_STATE, 0, "dis_state");
        push(cyc + 1, K_RD, 0, "dis_rd");
        push(cyc + 1, K_SLOT, 0, "dis_slot");
        push(cyc + 3, K_VEC, 8'hFF, "dis_vec_hold");
        run_to(cyc + 3);
        i_qgc_enable = 1'b1;
        pulse_start(t0);
        push(t0 + 1, K_VEC, 8'hFF, "reen_vec");
        expect_run(t0, 10, 3, 3, t0 + 100);
        tick();
        i_timer_rst = 1'b0;
        run_to(t0 + 2 + 3 * 10);

        // disable wins over a simultaneous cycle-start pulse
        i_qgc_enable = 1'b0;
        i_timer_rst = 1'b1;
        push(cyc + 1, K_STATE, 0, "dis_prio_state");
        push(cyc + 1, K_RD, 0, "dis_prio_rd");
        push(cyc + 1, K_VEC, 8'hFF, "dis_prio_vec");
        tick();
        i_timer_rst = 1'b0;
        i_qgc_enable = 1'b1;
        tick();

        // N = 0 behaves as a single-slot list
        gcl_mem[0] = 8'h5A;
        iv_time_slot_length = 16'd3;
        iv_cycle_slot_num = 11'd0;
        pulse_start(t0);
        expect_run(t0, 3, 0, 4, t0 + 100);
        tick();
        i_timer_rst = 1'b0;
        run_to(t0 + 2 + 4 * 3);

        // full-size list wraps at the top of the address space
        for (int i = 0; i < (1 << A); i++) gcl_mem[i] = 8'(i * 7 + 3);
        iv_time_slot_length = 16'd2;
        iv_cycle_slot_num = 11'(1 << A);
        pulse_start(t0);
        expect_run(t0, 2, 1 << A, (1 << A) + 2, t0 + 100000);
        tick();
        i_timer_rst = 1'b0;
        run_to(t0 + 2 + ((1 << A) + 2) * 2);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
